// File: rtl/care_action_encoder.sv
// Care-button front end: synchronise and debounce each button, queue presses as
// pending, and offer them one at a time over valid/ready with a cooldown after each.
module care_action_encoder #(
    parameter logic [23:0] DEBOUNCE_CYCLES = 24'd50_000,
    parameter logic [23:0] COOLDOWN_CYCLES = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] btn_in,
    input  logic       ena,
    output logic       act_valid,
    input  logic       act_ready,
    output logic [2:0] act_code,
    output logic [5:0] act_onehot,
    output logic       busy,
    output logic [3:0] drop_count
);

    typedef enum logic [1:0] {IDLE, OFFER, COOLDOWN} state_t;

    state_t      state_q, state_d;
    logic [5:0]  sync1_q, sync2_q;
    logic [5:0]  stable_q, stable_prev_q;
    logic [23:0] db_cnt_q [6];
    logic [5:0]  pending_q, pending_d;
    logic [2:0]  sel_q, sel_d;
    logic [23:0] cd_cnt_q, cd_cnt_d;
    logic [3:0]  drop_q, drop_d;
    logic [5:0]  press, clr, drops;
    logic        unused_btn;

    assign unused_btn = ^btn_in[7:6];

    function automatic logic [2:0] lowest_idx(input logic [5:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [2:0] popcount6(input logic [5:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [2:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {2'b00, b};
        return (s > 5'd15) ? 4'hF : s[3:0];
    endfunction

    // Input path: two-flop synchroniser, then per-bit debounce of the synced level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int i = 0; i < 6; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q       <= btn_in[5:0];
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            for (int i = 0; i < 6; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] >= DEBOUNCE_CYCLES - 24'd1) begin
                    stable_q[i] <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 24'd1;
                end
            end
        end
    end

    assign press = stable_q & ~stable_prev_q;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cd_cnt_d = cd_cnt_q;
        clr      = '0;
        case (state_q)
            IDLE: begin
                if (ena && (pending_q != 6'd0)) begin
                    state_d = OFFER;
                    sel_d   = lowest_idx(pending_q);
                end
            end
            OFFER: begin
                if (act_ready) begin
                    clr      = 6'd1 << sel_q;
                    cd_cnt_d = COOLDOWN_CYCLES - 24'd1;
                    state_d  = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (cd_cnt_q == 24'd0) state_d = IDLE;
                else                   cd_cnt_d = cd_cnt_q - 24'd1;
            end
            default: state_d = IDLE;
        endcase
        // A press landing on the bit being cleared re-queues and is not a drop.
        drops     = press & pending_q & ~clr;
        pending_d = (pending_q & ~clr) | press;
        drop_d    = sat_add4(drop_q, popcount6(drops));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            cd_cnt_q  <= '0;
            pending_q <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cd_cnt_q  <= cd_cnt_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    assign act_valid  = (state_q == OFFER);
    assign act_code   = act_valid ? (sel_q + 3'd1) : 3'd0;
    assign act_onehot = act_valid ? (6'd1 << sel_q) : 6'd0;
    assign busy       = (state_q != IDLE);
    assign drop_count = drop_q;

endmodule

// File: tb/tb_care_action_encoder.sv
// Scoreboard bench for care_action_encoder with short debounce/cooldown settings.
module tb_care_action_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] btn_in = 8'h00;
    logic       ena = 1'b0;
    logic       act_ready = 1'b0;
    logic       act_valid;
    logic [2:0] act_code;
    logic [5:0] act_onehot;
    logic       busy;
    logic [3:0] drop_count;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int got_rd = 0;

    logic [8:0] exp_q [$];
    logic [8:0] got_q [$];
    int         hs_q  [$];

    care_action_encoder #(
        .DEBOUNCE_CYCLES(24'd4),
        .COOLDOWN_CYCLES(24'd8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .ena       (ena),
        .act_valid (act_valid),
        .act_ready (act_ready),
        .act_code  (act_code),
        .act_onehot(act_onehot),
        .busy      (busy),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted action as {onehot, code} with its cycle stamp.
    always @(negedge clk) begin
        if (rst_n && act_valid && act_ready) begin
            got_q.push_back({act_onehot, act_code});
            hs_q.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++; if (act_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", act_valid); end
        checks++; if (act_code !== 3'd0) begin fails++; $display("FAIL reset_code: got %0d, required 0", act_code); end
        checks++; if (act_onehot !== 6'd0) begin fails++; $display("FAIL reset_onehot: got %h, required 00", act_onehot); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (drop_count !== 4'd0) begin fails++; $display("FAIL reset_drop: got %0d, required 0", drop_count); end
        rst_n = 1'b1;
        ena   = 1'b1;
        tick(2);
    endtask

    task automatic test_single_press();
        logic seen;
        int   busy_n, pulses;
        logic [8:0] g, e;
        act_ready = 1'b1;
        btn_in    = 8'h01;
        exp_q.push_back({6'h01, 3'd1});
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            tick(1);
            if (act_valid) seen = 1'b1;
        end
        checks++; if (!seen) begin fails++; $display("FAIL single_timeout: got no act_valid in 30 cycles, required one"); end
        busy_n = 0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (act_valid) pulses++;
            else if (busy) busy_n++;
        end
        checks++; if (busy_n != 8) begin fails++; $display("FAIL single_cooldown: got %0d busy cycles, required 8", busy_n); end
        checks++; if (pulses != 0) begin fails++; $display("FAIL single_repeat: got %0d extra valid cycles, required 0", pulses); end
        btn_in = 8'h00;
        tick(12);
        checks++;
        if ((got_q.size() - got_rd) != exp_q.size()) begin
            fails++; $display("FAIL single_count: got %0d actions, required %0d", got_q.size() - got_rd, exp_q.size());
        end
        while (got_rd < got_q.size() && exp_q.size() > 0) begin
            g = got_q[got_rd]; got_rd++;
            e = exp_q.pop_front();
            checks++; if (g !== e) begin fails++; $display("FAIL single_action: got %h, required %h", g, e); end
        end
        exp_q.delete();
        got_rd = got_q.size();
    endtask

    task automatic test_bounce();
        logic any_valid;
        any_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            btn_in[1] = ~btn_in[1];
            tick(1); any_valid |= act_valid;
            tick(1); any_valid |= act_valid;
        end
        btn_in = 8'h00;
        for (int k = 0; k < 10; k++) begin
            tick(1); any_valid |= act_valid;
        end
        checks++; if (any_valid !== 1'b0) begin fails++; $display("FAIL bounce_valid: got act_valid high, required never"); end
        checks++; if (drop_count !== 4'd0) begin fails++; $display("FAIL bounce_drop: got %0d, required 0", drop_count); end
        checks++; if (got_q.size() != got_rd) begin fails++; $display("FAIL bounce_actions: got %0d, required 0", got_q.size() - got_rd); end
        got_rd = got_q.size();
    endtask

    task automatic test_multi_press();
        logic [8:0] g, e;
        int gap;
        act_ready = 1'b1;
        btn_in    = 8'h24;
        exp_q.push_back({6'h04, 3'd3});
        exp_q.push_back({6'h20, 3'd6});
        for (int k = 0; k < 60 && (got_q.size() - got_rd) < 2; k++) tick(1);
        checks++;
        if ((got_q.size() - got_rd) != 2) begin
            fails++; $display("FAIL multi_count: got %0d actions, required 2", got_q.size() - got_rd);
        end
        if (hs_q.size() >= 2) begin
            gap = hs_q[hs_q.size() - 1] - hs_q[hs_q.size() - 2];
            checks++; if (gap != 10) begin fails++; $display("FAIL multi_gap: got %0d cycles between accepts, required 10", gap); end
        end
        while (got_rd < got_q.size() && exp_q.size() > 0) begin
            g = got_q[got_rd]; got_rd++;
            e = exp_q.pop_front();
            checks++; if (g !== e) begin fails++; $display("FAIL multi_action: got %h, required %h", g, e); end
        end
        btn_in = 8'h00;
        tick(12);
        checks++; if (drop_count !== 4'd0) begin fails++; $display("FAIL multi_drop: got %0d, required 0", drop_count); end
        checks++; if (got_q.size() != got_rd) begin fails++; $display("FAIL multi_extra: got %0d extra actions, required 0", got_q.size() - got_rd); end
        exp_q.delete();
        got_rd = got_q.size();
    endtask

    task automatic test_hold_offer();
        logic seen, held;
        logic [8:0] g, e;
        act_ready = 1'b0;
        btn_in    = 8'h01;
        exp_q.push_back({6'h01, 3'd1});
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            tick(1);
            if (act_valid) seen = 1'b1;
        end
        checks++; if (!seen) begin fails++; $display("FAIL hold_timeout: got no act_valid in 30 cycles, required one"); end
        held = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ena = ~ena;
            tick(1);
            if (act_valid !== 1'b1 || act_code !== 3'd1) held = 1'b0;
        end
        checks++; if (!held) begin fails++; $display("FAIL hold_retract: got valid=%b code=%0d, required valid=1 code=1", act_valid, act_code); end
        ena       = 1'b1;
        act_ready = 1'b1;
        tick(1);
        checks++; if (act_valid !== 1'b0) begin fails++; $display("FAIL hold_accept_valid: got %b, required 0", act_valid); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL hold_accept_busy: got %b, required 1", busy); end
        btn_in = 8'h00;
        tick(12);
        checks++;
        if ((got_q.size() - got_rd) != 1) begin
            fails++; $display("FAIL hold_count: got %0d actions, required 1", got_q.size() - got_rd);
        end
        while (got_rd < got_q.size() && exp_q.size() > 0) begin
            g = got_q[got_rd]; got_rd++;
            e = exp_q.pop_front();
            checks++; if (g !== e) begin fails++; $display("FAIL hold_action: got %h, required %h", g, e); end
        end
        exp_q.delete();
        got_rd = got_q.size();
    endtask

    task automatic test_drop_saturate();
        logic seen;
        act_ready = 1'b0;
        btn_in    = 8'h01;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            tick(1);
            if (act_valid) seen = 1'b1;
        end
        checks++; if (!seen) begin fails++; $display("FAIL drop_timeout: got no act_valid in 30 cycles, required one"); end
        checks++; if (drop_count !== 4'd0) begin fails++; $display("FAIL drop_start: got %0d, required 0", drop_count); end
        for (int p = 0; p < 17; p++) begin
            btn_in = 8'h00;
            tick(8);
            btn_in = 8'h01;
            tick(8);
            if (p == 0) begin
                checks++; if (drop_count !== 4'd1) begin fails++; $display("FAIL drop_first: got %0d, required 1", drop_count); end
            end
        end
        checks++; if (drop_count !== 4'hF) begin fails++; $display("FAIL drop_sat: got %0d, required 15", drop_count); end
        checks++; if (act_valid !== 1'b1 || act_code !== 3'd1) begin
            fails++; $display("FAIL drop_offer: got valid=%b code=%0d, required valid=1 code=1", act_valid, act_code);
        end
    endtask

    task automatic test_reset_offer();
        btn_in = 8'h00;
        rst_n  = 1'b0;
        tick(1);
        checks++; if (act_valid !== 1'b0) begin fails++; $display("FAIL rst_offer_valid: got %b, required 0", act_valid); end
        checks++; if (act_code !== 3'd0) begin fails++; $display("FAIL rst_offer_code: got %0d, required 0", act_code); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_offer_busy: got %b, required 0", busy); end
        checks++; if (drop_count !== 4'd0) begin fails++; $display("FAIL rst_offer_drop: got %0d, required 0", drop_count); end
        rst_n = 1'b1;
        tick(10);
        checks++; if (act_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_offer_idle: got valid=%b busy=%b, required 0 0", act_valid, busy);
        end
        checks++; if (got_q.size() != got_rd) begin fails++; $display("FAIL rst_offer_actions: got %0d, required 0", got_q.size() - got_rd); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_press();
        test_hold_offer();
        test_drop_saturate();
        test_reset_offer();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
